// File: rtl/bus_term_event_capture.sv
// bus_term_event_capture
//   Capture stage behind the cv_bus_term array. Each lane is synchronised,
//   and its rising and falling edges are detected. A saturating transition
//   count is kept per lane. Timestamped edge events are queued in a small
//   FIFO that is drained through a valid/ready handshake.
//
// Ports
//   clk       clock
//   rstb      synchronous active-low reset
//   VDD, VSS  supply pins, no logical function
//   in        asynchronous lane levels (one bit per array element)
//   en        capture enable (gates events and counting)
//   clr_cnt   synchronous clear of the per-lane counters and ovf
//   level     synchronised lane levels
//   cnt       per-lane transition counts, lane i at cnt[i*CNT_W +: CNT_W]
//   ovf       sticky flag: an event was dropped because the FIFO was full
//   ev_valid  FIFO head valid
//   ev_ready  consumer ready
//   ev_data   FIFO head {ts, rise[NLANE-1:0], fall[NLANE-1:0]}
module bus_term_event_capture #(
   parameter int NLANE       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int TS_W        = 12,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic                      VDD,
   input  logic                      VSS,
   input  logic [NLANE-1:0]          in,
   input  logic                      en,
   input  logic                      clr_cnt,
   output logic [NLANE-1:0]          level,
   output logic [NLANE*CNT_W-1:0]    cnt,
   output logic                      ovf,
   output logic                      ev_valid,
   input  logic                      ev_ready,
   output logic [TS_W+2*NLANE-1:0]   ev_data
);

   localparam int EW = TS_W + 2*NLANE;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic unused_supply;
   assign unused_supply = VDD ^ VSS;

   logic [NLANE-1:0] sync_ff [SYNC_STAGES];
   logic [NLANE-1:0] s;
   logic [NLANE-1:0] p;
   logic [NLANE-1:0] rise;
   logic [NLANE-1:0] fall;
   logic             push;
   logic [TS_W-1:0]  ts;
   logic [CNT_W-1:0] cnt_q [NLANE];
   logic [EW-1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             wr;
   logic             rd;

   // ---- stage: synchroniser chain, previous-level register, timestamp ----
   // p follows s regardless of en so a re-enable never sees a stale level.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_ff[k] <= '0;
         p  <= '0;
         ts <= '0;
      end else begin
         sync_ff[0] <= in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_ff[k] <= sync_ff[k-1];
         p  <= s;
         ts <= ts + 1'b1;
      end
   end

   assign s     = sync_ff[SYNC_STAGES-1];
   assign level = s;

   always_comb begin
      rise = '0;
      fall = '0;
      if (en) begin
         rise = s & ~p;
         fall = ~s & p;
      end
   end

   assign push = |(rise | fall);

   // ---- stage: per-lane counters and sticky overflow ----
   always_ff @(posedge clk) begin
      if (!rstb) begin
         for (int i = 0; i < NLANE; i++) cnt_q[i] <= '0;
         ovf <= 1'b0;
      end else if (clr_cnt) begin
         for (int i = 0; i < NLANE; i++) cnt_q[i] <= '0;
         ovf <= 1'b0;
      end else begin
         for (int i = 0; i < NLANE; i++)
            if (rise[i] | fall[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
         // A full FIFO only drops when nothing leaves in the same cycle.
         if (push && full && !rd) ovf <= 1'b1;
      end
   end

   for (genvar g = 0; g < NLANE; g++) begin : g_cnt
      assign cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end

   // ---- stage: event FIFO ----
   assign full     = (count == FULL_CNT);
   assign ev_valid = (count != '0);
   assign rd       = ev_valid & ev_ready;
   assign wr       = push & (~full | rd);

   always_ff @(posedge clk) begin
      if (!rstb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is data-only; ev_data is masked so it reads 0 when empty.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= {ts, rise, fall};
   end

   assign ev_data = ev_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_bus_term_event_capture.sv
module tb_bus_term_event_capture;

   localparam int NL    = 2;
   localparam int SS    = 2;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rstb;
   logic        VDD;
   logic        VSS;
   logic [1:0]  in;
   logic        en;
   logic        clr_cnt;
   logic [1:0]  level;
   logic [15:0] cnt;
   logic        ovf;
   logic        ev_valid;
   logic        ev_ready;
   logic [15:0] ev_data;

   int n_chk;
   int n_err;

   // reference model state
   logic [1:0]  m_sync [SS];
   logic [1:0]  m_p;
   logic [11:0] m_ts;
   logic [7:0]  m_cnt [NL];
   logic        m_ovf;
   logic [15:0] exp_q [$];

   bus_term_event_capture #(
      .NLANE(2), .SYNC_STAGES(2), .CNT_W(8), .TS_W(12), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rstb(rstb), .VDD(VDD), .VSS(VSS), .in(in), .en(en),
      .clr_cnt(clr_cnt), .level(level), .cnt(cnt), .ovf(ovf),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs as they stand, then
   // let the DUT take the same edge and compare the visible state.
   task automatic step();
      logic [1:0] s, rise, fall;
      logic       pop, full, drop;
      if (!rstb) begin
         for (int k = 0; k < SS; k++) m_sync[k] = '0;
         m_p   = '0;
         m_ts  = '0;
         for (int i = 0; i < NL; i++) m_cnt[i] = '0;
         m_ovf = 1'b0;
         exp_q.delete();
      end else begin
         s    = m_sync[SS-1];
         rise = en ? (s & ~m_p) : 2'b00;
         fall = en ? (~s & m_p) : 2'b00;
         full = (exp_q.size() == DEPTH);
         pop  = (exp_q.size() > 0) && ev_ready;
         drop = 1'b0;
         if (pop) begin
            check_val("ev_data", ev_data, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (|(rise | fall)) begin
            if (!full || pop) exp_q.push_back({m_ts, rise, fall});
            else drop = 1'b1;
         end
         for (int i = 0; i < NL; i++) begin
            if (clr_cnt) m_cnt[i] = '0;
            else if ((rise[i] | fall[i]) && m_cnt[i] != 8'hFF) m_cnt[i] = m_cnt[i] + 8'd1;
         end
         if (clr_cnt) m_ovf = 1'b0;
         else if (drop) m_ovf = 1'b1;
         for (int k = SS-1; k > 0; k--) m_sync[k] = m_sync[k-1];
         m_sync[0] = in;
         m_p  = s;
         m_ts = m_ts + 12'd1;
      end
      @(posedge clk);
      #1;
      check_val("level", level, m_sync[SS-1]);
      check_val("cnt", cnt, {m_cnt[1], m_cnt[0]});
      check_val("ovf", ovf, m_ovf);
      check_val("ev_valid", ev_valid, exp_q.size() > 0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      clk = 0; rstb = 0; VDD = 1; VSS = 0;
      in = 2'b00; en = 0; clr_cnt = 0; ev_ready = 0;

      // reset state
      repeat (3) step();
      check_val("rst_ev_data", ev_data, 16'h0000);
      check_val("rst_cnt", cnt, 16'h0000);

      // idle with inputs low
      rstb = 1;
      repeat (10) step();
      check_val("idle_valid", ev_valid, 1'b0);

      // first event timing: input changes at the first edge after reset
      rstb = 0;
      step();
      rstb = 1; in = 2'b01; en = 1; ev_ready = 1;
      repeat (3) step();
      check_val("first_valid", ev_valid, 1'b1);
      check_val("first_ev", ev_data, {12'd2, 2'b01, 2'b00});
      repeat (4) step();
      in = 2'b00;
      repeat (6) step();
      check_val("cnt_after_fall", cnt, {8'd0, 8'd2});

      // simultaneous rise on both lanes
      in = 2'b11;
      repeat (6) step();
      check_val("cnt_both", cnt, {8'd1, 8'd3});

      // overflow: five lane1 toggles with the consumer stalled
      ev_ready = 0;
      for (int t = 0; t < 5; t++) begin
         in[1] = ~in[1];
         repeat (2) step();
      end
      repeat (3) step();
      check_val("ovf_set", ovf, 1'b1);
      check_val("ovf_held", ev_valid, 1'b1);
      ev_ready = 1;
      repeat (6) step();
      check_val("ovf_sticky", ovf, 1'b1);
      check_val("drained", ev_valid, 1'b0);
      clr_cnt = 1;
      step();
      clr_cnt = 0;
      check_val("clr_ovf", ovf, 1'b0);
      check_val("clr_cnt", cnt, 16'h0000);

      // saturation of lane0
      for (int t = 0; t < 300; t++) begin
         in[0] = ~in[0];
         step();
      end
      repeat (4) step();
      check_val("sat_lane0", cnt[7:0], 8'hFF);
      clr_cnt = 1;
      step();
      clr_cnt = 0;

      // full FIFO meeting push and pop on the same edge
      ev_ready = 0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 7) ev_ready = 1;
         in[0] = ~in[0];
         step();
      end
      repeat (6) step();
      check_val("fullpp_ovf", ovf, 1'b0);
      check_val("fullpp_cnt0", cnt[7:0], 8'd8);

      // en low: toggles produce nothing and counts freeze
      en = 0;
      for (int t = 0; t < 4; t++) begin
         in = in ^ 2'b11;
         step();
      end
      in = in ^ 2'b01;
      repeat (4) step();
      check_val("dis_valid", ev_valid, 1'b0);
      check_val("dis_cnt0", cnt[7:0], 8'd8);
      en = 1;
      repeat (4) step();
      check_val("reen_valid", ev_valid, 1'b0);

      // reset with three events queued
      ev_ready = 0;
      for (int t = 0; t < 3; t++) begin
         in[1] = ~in[1];
         repeat (2) step();
      end
      repeat (2) step();
      check_val("q3_valid", ev_valid, 1'b1);
      rstb = 0; in = 2'b10;
      step();
      check_val("mrst_valid", ev_valid, 1'b0);
      check_val("mrst_cnt", cnt, 16'h0000);
      check_val("mrst_data", ev_data, 16'h0000);
      rstb = 1;
      repeat (3) step();
      check_val("mrst_ts", ev_data, {12'd2, 2'b10, 2'b00});
      ev_ready = 1;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
